// File: rtl/multicycle_maindec_if.sv
// Control bundle between the multicycle main decoder and the datapath.
// master = decoder side, slave = datapath side.
interface multicycle_maindec_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       memread;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zext;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, zext, aluop, pcsrc, pcen, state,
           instr_done, illegal, mem_timeout
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, zext, aluop, pcsrc, pcen, state,
           instr_done, illegal, mem_timeout
  );
endinterface

// File: rtl/multicycle_maindec.sv
// Multicycle MIPS main control FSM with memory-ready stalls and wait watchdog.
// Optional: define MAINDEC_BNE_EN to decode BNE (op 000101) through BREX.
module multicycle_maindec #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                 clk,
  input logic                 resetn,
  multicycle_maindec_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BREX   = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JEX    = 4'd11
  } state_e;

  localparam int unsigned CW        = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam int unsigned WAIT_LAST = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam bit          WD_EN     = (MEM_WAIT_MAX != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  state_e         state_q, state_d;
  logic [CW-1:0]  wcnt_q, wcnt_d;

  logic           mem_state, stall, timeout;
  state_e         decode_ns;
  logic           op_illegal;
  logic           zext_imm;
  logic           br_take;

  logic memread_c, memwrite_c, iord_c, irwrite_c, regwrite_c, regdst_c;
  logic memtoreg_c, alusrca_c, zext_c, pcen_c, instr_done_c, illegal_c;
  logic [1:0] alusrcb_c, aluop_c, pcsrc_c;

  logic unused_funct;
  assign unused_funct = ^ctrl.funct;

  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign stall     = mem_state && !ctrl.mem_ready;
  // The current stall cycle is the MEM_WAIT_MAX-th when the count of earlier ones is MAX-1.
  assign timeout   = WD_EN && stall && (wcnt_q == WAIT_LAST[CW-1:0]);

  assign zext_imm  = (ctrl.op[5:2] == 4'b0011) && (ctrl.op != OP_LUI);

`ifdef MAINDEC_BNE_EN
  assign br_take = (ctrl.op == OP_BNE) ? !ctrl.zero : ctrl.zero;
`else
  assign br_take = ctrl.zero;
`endif

  always_comb begin
    decode_ns  = FETCH;
    op_illegal = 1'b0;
    case (ctrl.op) inside
      OP_RTYPE:     decode_ns = REX;
      OP_LW, OP_SW: decode_ns = MEMADR;
      OP_BEQ:       decode_ns = BREX;
`ifdef MAINDEC_BNE_EN
      OP_BNE:       decode_ns = BREX;
`endif
      OP_J:         decode_ns = JEX;
      6'b001???:    decode_ns = IEX;
      default:      op_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (timeout) state_d = FETCH;
               else if (ctrl.mem_ready) state_d = DECODE;
      DECODE:  state_d = decode_ns;
      MEMADR:  state_d = (ctrl.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (timeout) state_d = FETCH;
               else if (ctrl.mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (timeout || ctrl.mem_ready) state_d = FETCH;
      REX:     state_d = RWB;
      RWB:     state_d = FETCH;
      IEX:     state_d = IWB;
      IWB:     state_d = FETCH;
      BREX:    state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Staying in a memory state only happens on a non-timeout stall, so any other cycle clears.
  always_comb begin
    wcnt_d = '0;
    if (stall && !timeout) begin
      wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + CW'(1);
    end
  end

  always_comb begin
    memread_c    = 1'b0;
    memwrite_c   = 1'b0;
    iord_c       = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    regdst_c     = 1'b0;
    memtoreg_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    zext_c       = 1'b0;
    aluop_c      = 2'b00;
    pcsrc_c      = 2'b00;
    pcen_c       = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = ctrl.mem_ready;
        pcen_c    = ctrl.mem_ready;
      end
      DECODE: begin
        alusrcb_c = 2'b11;
        illegal_c = op_illegal;
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      MEMWB: begin
        regwrite_c   = 1'b1;
        memtoreg_c   = 1'b1;
        instr_done_c = 1'b1;
      end
      MEMWR: begin
        memwrite_c   = 1'b1;
        iord_c       = 1'b1;
        instr_done_c = ctrl.mem_ready;
      end
      REX: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
      end
      RWB: begin
        regwrite_c   = 1'b1;
        regdst_c     = 1'b1;
        instr_done_c = 1'b1;
      end
      IEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        aluop_c   = 2'b11;
        zext_c    = zext_imm;
      end
      IWB: begin
        regwrite_c   = 1'b1;
        zext_c       = zext_imm;
        instr_done_c = 1'b1;
      end
      BREX: begin
        alusrca_c    = 1'b1;
        aluop_c      = 2'b01;
        pcsrc_c      = 2'b01;
        pcen_c       = br_take;
        instr_done_c = 1'b1;
      end
      JEX: begin
        pcsrc_c      = 2'b10;
        pcen_c       = 1'b1;
        instr_done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes and pulses are gated by resetn so an asynchronous reset kills any in-flight commit.
  assign ctrl.memread     = memread_c  & resetn;
  assign ctrl.memwrite    = memwrite_c & resetn;
  assign ctrl.irwrite     = irwrite_c  & resetn;
  assign ctrl.regwrite    = regwrite_c & resetn;
  assign ctrl.pcen        = pcen_c     & resetn;
  assign ctrl.instr_done  = instr_done_c & resetn;
  assign ctrl.illegal     = illegal_c  & resetn;
  assign ctrl.mem_timeout = timeout    & resetn;

  assign ctrl.iord     = iord_c;
  assign ctrl.regdst   = regdst_c;
  assign ctrl.memtoreg = memtoreg_c;
  assign ctrl.alusrca  = alusrca_c;
  assign ctrl.alusrcb  = alusrcb_c;
  assign ctrl.zext     = zext_c;
  assign ctrl.aluop    = aluop_c;
  assign ctrl.pcsrc    = pcsrc_c;
  assign ctrl.state    = state_q;

endmodule

// File: doc/multicycle_maindec.md
# multicycle_maindec

Main control FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder with a sequenced controller that drives one shared memory, the IR, ALU-source muxes and the PC. The sequencer stalls on a memory ready handshake and has a configurable wait watchdog. It sits between the instruction register (op/funct) and the datapath control points; `aludec` consumes its `aluop`.

## Interface
- `MEM_WAIT_MAX`, default 15: consecutive not-ready cycles tolerated in a memory state before abort. 0 disables the watchdog.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0]. Passed to `aludec` only; unused internally.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `memread`, `memwrite` out 1: memory strobes.
- `iord` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `irwrite` out 1: IR load enable.
- `regwrite`, `regdst`, `memtoreg` out 1: register file controls.
- `alusrca` out 1: ALU A input; 0 = PC, 1 = rs.
- `alusrcb` out 2: ALU B input; 00 = rt, 01 = 4, 10 = ext imm, 11 = sext imm<<2.
- `zext` out 1: immediate zero-extended (ANDI/ORI/XORI).
- `aluop` out 2: 00 add, 01 sub, 10 funct-decoded, 11 op-decoded.
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `pcen` out 1: PC write enable.
- `state` out 4: current state, for debug.
- `instr_done`, `illegal`, `mem_timeout` out 1: one-cycle status pulses.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BREX=8, IEX=9, IWB=10, JEX=11. Codes 12–15 are unreachable; if entered, go to FETCH.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. When mem_ready=1: irwrite=1, pcen=1, then go to DECODE. Otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00; this computes the branch target into ALUOut. Next state by op:
  - 000000 → REX
  - 100011 or 101011 → MEMADR
  - 000100 → BREX
  - 000010 → JEX
  - 001000–001111 → IEX
  - any other op: illegal=1, go to FETCH with no writes.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW → MEMRD, SW → MEMWR.
- MEMRD: memread=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1, then FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready; on mem_ready, instr_done=1 and go to FETCH.
- REX: alusrca=1, alusrcb=00, aluop=10, then RWB.
- RWB: regwrite=1, regdst=1, instr_done=1, then FETCH.
- IEX: alusrca=1, alusrcb=10, aluop=11, zext=1 for op 0011xx except LUI (001111), then IWB.
- IWB: regwrite=1, regdst=0, zext held as in IEX, instr_done=1, then FETCH.
- BREX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero, instr_done=1, then FETCH.
- JEX: pcsrc=10, pcen=1, instr_done=1, then FETCH.
- Unlisted outputs are 0 in every state.
- Watchdog counter:
  - Counts consecutive cycles with mem_ready=0 in FETCH, MEMRD and MEMWR; clears on any state change or on mem_ready=1.
  - When the count reaches MEM_WAIT_MAX with mem_ready still 0: mem_timeout=1 for that cycle, no strobe commits, next state FETCH, counter cleared.
  - Counter width is clog2(MEM_WAIT_MAX+1), saturating.

## Timing
- State and counter are registered. Outputs decode combinationally from state; pcen, irwrite, instr_done and the MEMWR commit are also qualified by mem_ready or zero in the same cycle.
- Reset (resetn=0): state=FETCH, counter=0. All strobes (memread, memwrite, irwrite, regwrite, pcen) and all pulses are forced to 0 while resetn=0. The first fetch request is issued in the first cycle after resetn rises.
- Reset asserted mid-instruction aborts immediately; no partial write may occur after resetn falls.
- Cycles per instruction with zero-wait memory: LW 5, SW 4, R-type 4, I-type 4, BEQ 3, J 3. Each mem_ready=0 cycle adds one cycle.
- mem_ready asserted in a non-memory state is ignored.

## Configuration
- `MAINDEC_BNE_EN`:
  - Defined: op 000101 (BNE) decodes to BREX, and pcen=~zero for BNE (op is held stable in the IR).
  - Undefined: 000101 is illegal (illegal pulse in DECODE, return to FETCH).

## Test plan
- Reset: hold resetn=0 for 3 cycles, release → state=0, memread=0 during reset, memread=1 in the first cycle after release; with mem_ready=1, irwrite=pcen=1, then state=1.
- LW 100011 with zero-wait memory → states 0,1,2,3,4; regwrite=memtoreg=1 only in state 4; instr_done pulses once; 5 cycles total.
- SW 101011 with mem_ready low for 3 cycles in MEMWR → MEMWR held 4 cycles, memwrite=1 throughout; instr_done in the mem_ready cycle; no regwrite.
- BEQ 000100 with zero=1 → pcen=1 and pcsrc=01 in BREX. With zero=0 → pcen=0. Both take 3 cycles.
- ORI 001101 → IEX/IWB with aluop=11, zext=1. LUI 001111 → zext=0. op 111111 → illegal=1 in DECODE, back to FETCH, no writes.
- MEM_WAIT_MAX=4, mem_ready tied 0 in MEMRD → mem_timeout pulses on the 4th stall cycle, next state FETCH, regwrite never asserted.
